// File: rtl/bram_pkg.sv
// bram_pkg: shared write-mode constants, clear-sweep states and lane-count helper for bram_dp.
package bram_pkg;
   localparam int WM_READ_FIRST  = 0;
   localparam int WM_WRITE_FIRST = 1;
   localparam int WM_NO_CHANGE   = 2;
   typedef enum logic {CLR_CLEAR, CLR_READY} bram_clr_state_t;
   function automatic int calc_nb(input int dw, input int bw);
      return dw / bw;
   endfunction
endpackage

// File: rtl/bram_clear_fsm.sv
// bram_clear_fsm: post-reset sweep that zeroes every word, holding busy until the array is clean.
module bram_clear_fsm
   import bram_pkg::*;
#(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);
   bram_clr_state_t state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLR_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLR_CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (&cnt_q) state_d = CLR_READY;
      end
   end
   assign busy     = state_q == CLR_CLEAR;
   assign clr_we   = busy;
   assign clr_addr = cnt_q;
endmodule

// File: rtl/bram_dp.sv
// bram_dp: single-clock true dual-port RAM with byte enables, compile-time write mode and clear sweep.
// Define BRAM_DP_OUT_REG_EN to add an output register stage (read latency 2).
module bram_dp
   import bram_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 9,
   parameter int BYTE_WIDTH = 8,
   parameter int WRITE_MODE = 0,
   localparam int NB        = calc_nb(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                  clka,
   input  logic                  rsta,
   output logic                  busy,
   input  logic                  ena,
   input  logic [NB-1:0]         wea,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [DATA_WIDTH-1:0] dina,
   output logic [DATA_WIDTH-1:0] douta,
   input  logic                  enb,
   input  logic [NB-1:0]         web,
   input  logic [ADDR_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0] dinb,
   output logic [DATA_WIDTH-1:0] doutb,
   output logic                  coll
);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  acc_a, acc_b, same;
   logic [NB-1:0]         wa, wb;
   logic [DATA_WIDTH-1:0] old_a, old_b, mrg_a, mrg_b;
   logic [DATA_WIDTH-1:0] douta_q, douta_d, doutb_q, doutb_d;
   logic                  coll_q, coll_d;

   bram_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
      .clk(clka), .rst(rsta), .busy(busy), .clr_we(clr_we), .clr_addr(clr_addr)
   );

   assign acc_a = ena & ~busy;
   assign acc_b = enb & ~busy;
   assign wa    = acc_a ? wea : '0;
   assign wb    = acc_b ? web : '0;
   assign same  = addra == addrb;
   assign old_a = mem[addra];
   assign old_b = mem[addrb];

   always_comb begin
      mrg_a = old_a;
      mrg_b = old_b;
      for (int i = 0; i < NB; i++) begin
         if (wa[i]) mrg_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
         if (wb[i]) mrg_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // A non-writing port on a colliding address naturally sees the old word here.
   always_comb begin
      douta_d = douta_q;
      doutb_d = doutb_q;
      if (acc_a)
         douta_d = (WRITE_MODE == WM_NO_CHANGE && |wa) ? douta_q :
                   (WRITE_MODE == WM_WRITE_FIRST) ? mrg_a : old_a;
      if (acc_b)
         doutb_d = (WRITE_MODE == WM_NO_CHANGE && |wb) ? doutb_q :
                   (WRITE_MODE == WM_WRITE_FIRST) ? mrg_b : old_b;
      coll_d = acc_a & acc_b & same & (|wa | |wb);
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         douta_q <= '0;
         doutb_q <= '0;
         coll_q  <= 1'b0;
      end else begin
         douta_q <= douta_d;
         doutb_q <= doutb_d;
         coll_q  <= coll_d;
      end
   end

   // Port A's lane write is issued last so it wins lanes both ports enable.
   always_ff @(posedge clka) begin
      if (clr_we) mem[clr_addr] <= '0;
      else
         for (int i = 0; i < NB; i++) begin
            if (wb[i]) mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wa[i]) mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
   end

`ifdef BRAM_DP_OUT_REG_EN
   logic [DATA_WIDTH-1:0] douta_r_q, douta_r_d, doutb_r_q, doutb_r_d;
   logic                  coll_r_q, coll_r_d;
   always_comb begin
      douta_r_d = ena ? douta_q : douta_r_q;
      doutb_r_d = enb ? doutb_q : doutb_r_q;
      coll_r_d  = coll_q;
   end
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         douta_r_q <= '0;
         doutb_r_q <= '0;
         coll_r_q  <= 1'b0;
      end else begin
         douta_r_q <= douta_r_d;
         doutb_r_q <= doutb_r_d;
         coll_r_q  <= coll_r_d;
      end
   end
   assign douta = douta_r_q;
   assign doutb = doutb_r_q;
   assign coll  = coll_r_q;
`else
   assign douta = douta_q;
   assign doutb = doutb_q;
   assign coll  = coll_q;
`endif
endmodule

// File: tb/tb_bram_dp.sv
// tb_bram_dp: directed checks of bram_dp in all three write modes sharing one stimulus stream.
module tb_bram_dp;
`ifdef BRAM_DP_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic        clk = 1'b0, rsta = 1'b0;
   logic        ena = 1'b0, enb = 1'b0;
   logic [1:0]  wea = '0, web = '0;
   logic [3:0]  addra = '0, addrb = '0;
   logic [15:0] dina = '0, dinb = '0;
   logic [15:0] douta [3];
   logic [15:0] doutb [3];
   logic        busy [3];
   logic        coll [3];
   int          passed = 0, total = 0, n;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      bram_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .WRITE_MODE(k)) u_dut (
         .clka(clk), .rsta(rsta), .busy(busy[k]),
         .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[k]),
         .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[k]),
         .coll(coll[k])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic acc(input logic ea, input logic [1:0] wa_, input logic [3:0] aa, input logic [15:0] da,
                      input logic eb, input logic [1:0] wb_, input logic [3:0] ab, input logic [15:0] db);
      ena = ea; wea = wa_; addra = aa; dina = da;
      enb = eb; web = wb_; addrb = ab; dinb = db;
      tick();
      if (LAT == 2) begin
         wea = '0; web = '0;
         tick();
      end
      ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      for (int i = 0; i < 40 && busy[0]; i++) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ena = 1'b1; wea = 2'b11; addra = 4'd3; dina = 16'hFFFF;
      #2 rsta = 1'b1;
      #1;
      chk("rst_busy", 16'(busy[0]), 16'd1);
      chk("rst_douta", douta[0], 16'h0);
      chk("rst_doutb", doutb[0], 16'h0);
      chk("rst_coll", 16'(coll[0]), 16'd0);
      tick();
      tick();
      rsta = 1'b0;
      count_busy(n);
      chk("sweep_len", 16'(n), 16'd16);
      ena = 1'b0; wea = '0;
      chk("sweep_douta", douta[0], 16'h0);
      for (int a = 0; a < 16; a++) begin
         acc(1, 2'b00, 4'(a), 16'h0, 0, 2'b00, 4'd0, 16'h0);
         chk($sformatf("clear_%0d", a), douta[0], 16'h0);
      end
      acc(1, 2'b11, 4'd3, 16'hBEEF, 0, 2'b00, 4'd0, 16'h0);
      acc(1, 2'b01, 4'd3, 16'h1234, 0, 2'b00, 4'd0, 16'h0);
      acc(0, 2'b00, 4'd0, 16'h0, 1, 2'b00, 4'd3, 16'h0);
      chk("byte_wr", doutb[0], 16'hBE34);
      acc(1, 2'b11, 4'd5, 16'h1111, 0, 2'b00, 4'd0, 16'h0);
      acc(1, 2'b00, 4'd3, 16'h0, 0, 2'b00, 4'd0, 16'h0);
      acc(1, 2'b11, 4'd5, 16'h2222, 0, 2'b00, 4'd0, 16'h0);
      chk("wm_read_first", douta[0], 16'h1111);
      chk("wm_write_first", douta[1], 16'h2222);
      chk("wm_no_change", douta[2], 16'hBE34);
      acc(0, 2'b00, 4'd0, 16'h0, 1, 2'b00, 4'd5, 16'h0);
      chk("wm_stored", doutb[2], 16'h2222);
      addra = 4'd3;
      tick();
      chk("hold_en0", douta[0], 16'h1111);
      acc(1, 2'b10, 4'd7, 16'hAAAA, 1, 2'b11, 4'd7, 16'hBBBB);
      chk("ww_coll", 16'(coll[0]), 16'd1);
      tick();
      chk("ww_coll_once", 16'(coll[0]), 16'd0);
      acc(1, 2'b00, 4'd7, 16'h0, 0, 2'b00, 4'd0, 16'h0);
      chk("ww_data", douta[0], 16'hAABB);
      acc(1, 2'b11, 4'd9, 16'h0F0F, 0, 2'b00, 4'd0, 16'h0);
      acc(1, 2'b11, 4'd9, 16'hF0F0, 1, 2'b00, 4'd9, 16'h0);
      chk("rw_old_rf", doutb[0], 16'h0F0F);
      chk("rw_old_wf", doutb[1], 16'h0F0F);
      chk("rw_old_nc", doutb[2], 16'h0F0F);
      chk("rw_coll", 16'(coll[0]), 16'd1);
      acc(0, 2'b00, 4'd0, 16'h0, 1, 2'b00, 4'd9, 16'h0);
      chk("rw_new", doutb[0], 16'hF0F0);
      rsta = 1'b1;
      #1;
      chk("rst2_douta", douta[0], 16'h0);
      chk("rst2_doutb", doutb[0], 16'h0);
      tick();
      rsta = 1'b0;
      repeat (6) tick();
      chk("mid_busy", 16'(busy[0]), 16'd1);
      rsta = 1'b1;
      #1;
      chk("mid_coll", 16'(coll[0]), 16'd0);
      tick();
      rsta = 1'b0;
      count_busy(n);
      chk("mid_sweep_len", 16'(n), 16'd16);
      acc(1, 2'b00, 4'd7, 16'h0, 1, 2'b00, 4'd9, 16'h0);
      chk("mid_clear_a", douta[0], 16'h0);
      chk("mid_clear_b", doutb[0], 16'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
